bf2_pipe: RTL
=============

BF2_PIPE -- requirements
Module: bf2_pipe

Interface
REQ-001 SHALL have parameter WD, default 12, meaning signed width of every data input and output (WD >= 4).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the saturation event counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an input beat this cycle.
REQ-007 SHALL have ports din_a_re, din_a_im, din_b_re, din_b_im  input  WD each  signed two's-complement operands A and B.
REQ-008 SHALL have port scale_en  input  1  per-beat mode: 1 = divide result by 2 with rounding, 0 = saturate.
REQ-009 SHALL have port out_valid  output  1  output beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts output beat.
REQ-011 SHALL have ports dout_a_re, dout_a_im, dout_b_re, dout_b_im  output  WD each  signed A+B (a outputs) and A-B (b outputs).
REQ-012 SHALL have port sat_flag  output  1  current output beat had at least one saturated component.
REQ-013 SHALL have port sat_clr  input  1  synchronous clear of sat_cnt.
REQ-014 SHALL have port sat_cnt  output  CNT_W  count of accepted output beats with sat_flag=1.

Function
REQ-015 SHALL be a two-stage pipeline: S1 registers the four WD+1-bit sums/differences plus scale_en; S2 registers the WD-bit scaled-or-saturated results plus sat_flag.
REQ-016 SHALL have a latency of exactly 2 cycles from an accepted input beat (in_valid & in_ready) to out_valid, when there is no backpressure.
REQ-017 SHALL load S2 when v2=0 or out_ready=1; SHALL load S1 when v1=0 or S2 loads; in_ready SHALL equal (v1=0 or S2 loads).
REQ-018 SHALL sustain one beat per cycle with out_ready held at 1; SHALL lose, duplicate or reorder no beat under any out_ready pattern.
REQ-019 SHALL hold every output and sat_flag stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, with scale_en=0, clamp each WD+1-bit value x to [-2^(WD-1), 2^(WD-1)-1] and set that component's saturation bit if clamped.
REQ-021 SHALL, with scale_en=1, output (x+1)>>>1 (arithmetic, round half up, computed in WD+2 bits); this path never saturates and sets no saturation bit.
REQ-022 SHALL set sat_flag to the OR of the four component saturation bits of the beat.
REQ-023 SHALL apply scale_en per beat, as sampled with that beat's data; mixed modes in flight SHALL not interact.
REQ-024 SHALL increment sat_cnt by 1 on each output handshake (out_valid & out_ready) with sat_flag=1, holding at 2^CNT_W-1 (no wrap).
REQ-025 SHALL, when sat_clr=1, set sat_cnt to 0 on the next edge; sat_clr SHALL take priority over a same-cycle increment.
REQ-026 SHALL ignore data inputs when in_valid=0 (bubbles propagate as v=0).

Reset
REQ-027 SHALL, while rst_n=0, force v1=v2=0, out_valid=0, sat_flag=0, sat_cnt=0 and all data registers to 0, asynchronously.
REQ-028 SHALL drive in_ready=1 during reset and on the first cycle after reset release.
REQ-029 SHALL discard in-flight beats when reset is asserted mid-operation; the first output after release SHALL come from a post-reset input.

Verification (WD=12)
REQ-030 SHALL pass: A=(2047,-2048), B=(2047,2047), scale_en=0 -> 2 cycles later a=(2047,-1), b=(0,-2048), sat_flag=1, sat_cnt=1.
REQ-031 SHALL pass: A=(2047,-2048), B=(2047,-2048), scale_en=1 -> a=(2047,-2048), b=(0,0), sat_flag=0; A=(3,-1), B=(-2,0) scaled -> a=(1,0), b=(3,0).
REQ-032 SHALL pass: 8 back-to-back beats, out_ready toggled 1,0,0,1,... -> all 8 outputs in order, held stable while stalled, in_ready=0 only when both stages are full and out_ready=0.
REQ-033 SHALL pass: CNT_W=2, 5 saturating beats -> sat_cnt reads 3 after the 3rd beat and stays 3; sat_clr pulsed with a 6th saturating handshake -> sat_cnt=0.
REQ-034 SHALL pass: rst_n pulled low with 2 beats in flight -> out_valid=0 immediately, no stale beat emitted after release, in_ready=1.

Source files
------------

// File: rtl/bf2_pipe.sv
// Radix-2 complex butterfly (A+B, A-B) in a two-stage valid/ready pipeline.
// Each beat is either halved with round-half-up or clamped to WD bits.
module bf2_pipe #(
    parameter int WD    = 12,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WD-1:0] din_a_re,
    input  logic signed [WD-1:0] din_a_im,
    input  logic signed [WD-1:0] din_b_re,
    input  logic signed [WD-1:0] din_b_im,
    input  logic                 scale_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WD-1:0] dout_a_re,
    output logic signed [WD-1:0] dout_a_im,
    output logic signed [WD-1:0] dout_b_re,
    output logic signed [WD-1:0] dout_b_im,
    output logic                 sat_flag,
    input  logic                 sat_clr,
    output logic [CNT_W-1:0]     sat_cnt
);

    localparam logic signed [WD:0] MAX_V = {2'b00, {(WD-1){1'b1}}};
    localparam logic signed [WD:0] MIN_V = {2'b11, {(WD-1){1'b0}}};
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};

    // Clamp to WD bits; the MSB of the result is the saturation bit.
    function automatic logic [WD:0] sat_fn(input logic signed [WD:0] x);
        logic [WD:0] res;
        if (x > MAX_V) begin
            res = {1'b1, MAX_V[WD-1:0]};
        end else if (x < MIN_V) begin
            res = {1'b1, MIN_V[WD-1:0]};
        end else begin
            res = {1'b0, x[WD-1:0]};
        end
        return res;
    endfunction

    // (x+1)>>>1 in WD+2 bits; the result always fits in WD bits.
    function automatic logic signed [WD-1:0] scale_fn(input logic signed [WD:0] x);
        return WD'(($signed({x[WD], x}) + $signed({{(WD+1){1'b0}}, 1'b1})) >>> 1);
    endfunction

    logic                 r_v1;
    logic                 r_scale1;
    logic signed [WD:0]   r_x1 [4];
    logic                 r_v2;
    logic                 r_sat2;
    logic signed [WD-1:0] r_y2 [4];
    logic [CNT_W-1:0]     r_sat_cnt;

    logic                 w_s2_load;
    logic                 w_s1_load;
    logic                 w_out_hs;
    logic signed [WD:0]   w_x [4];
    logic signed [WD-1:0] w_y [4];
    logic [3:0]           w_sat;

    assign w_s2_load = !r_v2 || out_ready;
    assign w_s1_load = !r_v1 || w_s2_load;
    assign w_out_hs  = r_v2 && out_ready;

    assign in_ready  = w_s1_load;
    assign out_valid = r_v2;
    assign sat_flag  = r_sat2;
    assign sat_cnt   = r_sat_cnt;
    assign dout_a_re = r_y2[0];
    assign dout_a_im = r_y2[1];
    assign dout_b_re = r_y2[2];
    assign dout_b_im = r_y2[3];

    // Full-precision sums and differences of the incoming operands.
    always_comb begin
        w_x[0] = $signed({din_a_re[WD-1], din_a_re}) + $signed({din_b_re[WD-1], din_b_re});
        w_x[1] = $signed({din_a_im[WD-1], din_a_im}) + $signed({din_b_im[WD-1], din_b_im});
        w_x[2] = $signed({din_a_re[WD-1], din_a_re}) - $signed({din_b_re[WD-1], din_b_re});
        w_x[3] = $signed({din_a_im[WD-1], din_a_im}) - $signed({din_b_im[WD-1], din_b_im});
    end

    // Per-component scale-or-saturate of the S1 contents, using the beat's own mode.
    always_comb begin
        w_sat = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            w_y[i] = '0;
            if (r_scale1) begin
                w_y[i]   = scale_fn(r_x1[i]);
                w_sat[i] = 1'b0;
            end else begin
                {w_sat[i], w_y[i]} = sat_fn(r_x1[i]);
            end
        end
    end

    // Stage 1: capture a new beat whenever the stage is empty or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_scale1 <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_x1[i] <= '0;
            end
        end else if (w_s1_load) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_scale1 <= scale_en;
                for (int i = 0; i < 4; i++) begin
                    r_x1[i] <= w_x[i];
                end
            end
        end
    end

    // Stage 2: hold the output beat until the downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_sat2 <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_y2[i] <= '0;
            end
        end else if (w_s2_load) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sat2 <= |w_sat;
                for (int i = 0; i < 4; i++) begin
                    r_y2[i] <= w_y[i];
                end
            end
        end
    end

    // Saturated-beat counter: clear wins, otherwise count handshakes and stick at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (w_out_hs && r_sat2 && (r_sat_cnt != CNT_MAX)) begin
            r_sat_cnt <= r_sat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
